mux_n_sync: RTL and testbench

//  Parametrised N-input, m-bit registered selector for the DDS datapath, e.g. choosing a waveform source.
//  A new select is requested any time; by default it takes effect only on a sync strobe (phase-accumulator

---
 rtl/mux_n_sync_pkg.sv | 23 ++
 rtl/mux_n_comb.sv | 20 ++
 rtl/mux_n_sync.sv | 80 ++++++++
 tb/tb_mux_n_sync.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_sync_pkg.sv
// Shared definitions for the registered N:1 selector: default sizes,
// the per-edge select action, and a ceil-log2 helper for select widths.
package mux_n_sync_pkg;

    localparam int unsigned M_DEF       = 12;
    localparam int unsigned N_DEF       = 4;
    localparam int unsigned SEL_RST_DEF = 0;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_APPLY_REQ,
        ACT_APPLY_NXT,
        ACT_DEFER
    } sel_act_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N:1 selector of m-bit channels packed in in_bus.
// An out-of-range select returns channel 0.
module mux_n_comb #(
    parameter int unsigned m    = 12,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N*m-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    output logic [m-1:0]    out
);

    always_comb begin
        out = in_bus[0 +: m];
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(sel) == k) out = in_bus[k*m +: m];
        end
    end

endmodule

// File: rtl/mux_n_sync.sv
// Registered N:1 selector whose select changes only on a sync strobe
// (or at once in immediate mode), with pending flag and range checking.
module mux_n_sync
    import mux_n_sync_pkg::*;
#(
    parameter int unsigned m       = M_DEF,
    parameter int unsigned N       = N_DEF,
    parameter int unsigned SELW    = clog2(N_DEF),
    parameter int unsigned SEL_RST = SEL_RST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*m-1:0]  in_bus,
    input  logic [SELW-1:0] sel_req,
    input  logic            sel_load,
    input  logic            sync,
    input  logic            immediate,
    output logic [m-1:0]    out,
    output logic [SELW-1:0] sel_cur,
    output logic            pending,
    output logic            switched,
    output logic            sel_err
);

    sel_act_e        act;
    logic            req_ok;
    logic [SELW-1:0] sel_nxt;
    logic [SELW-1:0] sel_new;
    logic [SELW-1:0] nxt_new;
    logic            pend_new;
    logic [m-1:0]    mux_out;

    assign req_ok = (32'(sel_req) < N);

    always_comb begin
        act      = ACT_HOLD;
        sel_new  = sel_cur;
        nxt_new  = sel_nxt;
        pend_new = pending;
        // An invalid load never disturbs a pending select, so sync may still apply it.
        if (sel_load && req_ok) act = (immediate || sync) ? ACT_APPLY_REQ : ACT_DEFER;
        else if (sync && pending) act = ACT_APPLY_NXT;
        case (act)
            ACT_APPLY_REQ: begin sel_new = sel_req; pend_new = 1'b0; end
            ACT_APPLY_NXT: begin sel_new = sel_nxt; pend_new = 1'b0; end
            ACT_DEFER:     begin nxt_new = sel_req; pend_new = 1'b1; end
            ACT_HOLD:      ;
        endcase
    end

    // Muxing on the select being written keeps out aligned with the switched pulse.
    mux_n_comb #(
        .m    (m),
        .N    (N),
        .SELW (SELW)
    ) u_mux (
        .in_bus (in_bus),
        .sel    (sel_new),
        .out    (mux_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_cur  <= SELW'(SEL_RST);
            sel_nxt  <= SELW'(SEL_RST);
            pending  <= 1'b0;
            switched <= 1'b0;
            sel_err  <= 1'b0;
            out      <= '0;
        end else begin
            sel_cur  <= sel_new;
            sel_nxt  <= nxt_new;
            pending  <= pend_new;
            switched <= (sel_new != sel_cur);
            sel_err  <= sel_load && !req_ok;
            out      <= mux_out;
        end
    end

endmodule

// File: tb/tb_mux_n_sync.sv
// Scoreboard bench for mux_n_sync: N=4 and N=3 instances share stimulus,
// each checked every cycle against a rule-level model.
module tb_mux_n_sync;

    localparam int M = 12;
    localparam logic [4*M-1:0] DB = {12'h0F3, 12'hABC, 12'h1F0, 12'h5A5};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4*M-1:0] bus_v = '0;
    logic [1:0] req = '0;
    logic load = 1'b0, sync = 1'b0, imm = 1'b0;
    logic [M-1:0] out4, out3;
    logic [1:0] cur4, cur3;
    logic pend4, pend3, sw4, sw3, err4, err3;
    logic [63:0] rb;

    always #5 clk = ~clk;

    mux_n_sync #(.m(M), .N(4), .SELW(2), .SEL_RST(0)) dut4 (
        .clk(clk), .rst(rst), .in_bus(bus_v), .sel_req(req), .sel_load(load),
        .sync(sync), .immediate(imm), .out(out4), .sel_cur(cur4),
        .pending(pend4), .switched(sw4), .sel_err(err4)
    );

    mux_n_sync #(.m(M), .N(3), .SELW(2), .SEL_RST(0)) dut3 (
        .clk(clk), .rst(rst), .in_bus(bus_v[3*M-1:0]), .sel_req(req), .sel_load(load),
        .sync(sync), .immediate(imm), .out(out3), .sel_cur(cur3),
        .pending(pend3), .switched(sw3), .sel_err(err3)
    );

    typedef struct {
        logic [M-1:0] out;
        logic [1:0]   cur;
        logic         pend;
        logic         sw;
        logic         err;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    exp_t me;
    int compared = 0;
    int mismatched = 0;
    int unsigned mcur[2];
    int unsigned mnxt[2];
    bit mpend[2];
    int unsigned nch[2] = '{4, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcur[i] = 0; mnxt[i] = 0; mpend[i] = 1'b0;
        end
        q4.delete();
        q3.delete();
    endtask

    // Drive one cycle of stimulus and push what each instance must show after the edge.
    task automatic cycle(input logic [4*M-1:0] b, input bit l, input logic [1:0] r,
                         input bit s, input bit im);
        exp_t e;
        int unsigned old;
        @(negedge clk);
        bus_v = b; load = l; req = r; sync = s; imm = im;
        for (int i = 0; i < 2; i++) begin
            old = mcur[i];
            e.err = l && (int'(r) >= int'(nch[i]));
            if (l && int'(r) < int'(nch[i])) begin
                if (im || s) begin mcur[i] = r; mpend[i] = 1'b0; end
                else begin mnxt[i] = r; mpend[i] = 1'b1; end
            end else if (s && mpend[i]) begin
                mcur[i] = mnxt[i]; mpend[i] = 1'b0;
            end
            e.cur  = 2'(mcur[i]);
            e.pend = mpend[i];
            e.sw   = (mcur[i] != old);
            e.out  = b[mcur[i]*M +: M];
            if (i == 0) q4.push_back(e); else q3.push_back(e);
        end
    endtask

    task automatic step(input bit l, input logic [1:0] r, input bit s, input bit im);
        cycle(DB, l, r, s, im);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state();
        check("rst_out4", out4, 0);  check("rst_cur4", cur4, 0);
        check("rst_pend4", pend4, 0); check("rst_sw4", sw4, 0);
        check("rst_err4", err4, 0);  check("rst_out3", out3, 0);
        check("rst_cur3", cur3, 0);  check("rst_pend3", pend3, 0);
    endtask

    // Caller sits just after a rising edge; reset is raised and checked between edges.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1 check_reset_state();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (q4.size() != 0) begin
                me = q4.pop_front();
                check("sb4_out", out4, me.out);   check("sb4_cur", cur4, me.cur);
                check("sb4_pend", pend4, me.pend); check("sb4_sw", sw4, me.sw);
                check("sb4_err", err4, me.err);
            end
            if (q3.size() != 0) begin
                me = q3.pop_front();
                check("sb3_out", out3, me.out);   check("sb3_cur", cur3, me.cur);
                check("sb3_pend", pend3, me.pend); check("sb3_sw", sw3, me.sw);
                check("sb3_err", err3, me.err);
            end
        end
    end

    initial begin
        #2 do_reset();

        // T1: reset with a pending select, then channel 0 one cycle after release
        step(1, 2'd1, 0, 0);
        check("t1_pend_before", pend4, 1);
        do_reset();
        step(0, 2'd0, 0, 0);
        check("t1_ch0", out4, 12'h5A5);

        // T2: deferred load, applied on sync
        repeat (3) step(0, 2'd0, 0, 0);
        step(1, 2'd2, 0, 0);
        check("t2_pend", pend4, 1);
        repeat (3) begin
            step(0, 2'd0, 0, 0);
            check("t2_pend_hold", pend4, 1);
        end
        step(0, 2'd0, 1, 0);
        check("t2_cur", cur4, 2);
        check("t2_sw", sw4, 1);
        check("t2_out", out4, 12'hABC);

        // T3: last load wins
        step(1, 2'd1, 0, 0);
        step(0, 2'd0, 0, 0);
        step(1, 2'd3, 0, 0);
        step(0, 2'd0, 1, 0);
        check("t3_cur", cur4, 3);
        check("t3_sw", sw4, 1);

        // T4: load with sync, and load with immediate
        step(1, 2'd2, 1, 0);
        check("t4_cur_sync", cur4, 2);
        check("t4_pend_sync", pend4, 0);
        step(1, 2'd0, 0, 1);
        step(1, 2'd2, 0, 1);
        check("t4_cur_imm", cur4, 2);
        check("t4_pend_imm", pend4, 0);

        // T5: out-of-range request on N=3 keeps the pending select
        step(1, 2'd1, 0, 0);
        step(1, 2'd3, 0, 0);
        check("t5_err3", err3, 1);
        check("t5_pend3", pend3, 1);
        check("t5_err4", err4, 0);
        step(0, 2'd0, 1, 0);
        check("t5_cur3", cur3, 1);
        check("t5_cur4", cur4, 3);

        // T6: same select clears pending without a switch
        step(1, 2'd2, 1, 0);
        step(1, 2'd2, 0, 0);
        check("t6_pend", pend4, 1);
        step(0, 2'd0, 1, 0);
        check("t6_pend_clr", pend4, 0);
        check("t6_sw", sw4, 0);
        check("t6_out", out4, 12'hABC);

        // Immediate rising alone does not apply a pending select
        step(1, 2'd1, 0, 0);
        step(0, 2'd0, 0, 1);
        check("imm_pend", pend4, 1);
        check("imm_cur", cur4, 2);
        step(0, 2'd0, 1, 0);
        check("imm_sync_cur", cur4, 1);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            if (n == 5000) begin
                @(posedge clk);
                #2 do_reset();
            end
            rb = {$urandom(), $urandom()};
            cycle(rb[4*M-1:0], $urandom_range(0, 3) == 0, 2'($urandom()),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        check("drain", q4.size() + q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
